// File: rtl/game_ctrl.sv
// game_ctrl: top-level sequencer for the dinosaur runner.
// Runs the IDLE/RUN/PAUSE/OVER state machine and the per-frame jump schedule.
// Keeps the score and the obstacle speed level; all frame work is gated by frame_tick.
module game_ctrl #(
  parameter int JUMP_FRAMES = 60,
  parameter int SCORE_W     = 16,
  parameter int SPEED_STEP  = 100,
  parameter int MAX_SPEED   = 7
) (
  input  logic               clk,
  input  logic               RESET_N,
  input  logic               frame_tick,
  input  logic               btn_start,
  input  logic               btn_jump,
  input  logic               collision,
  output logic               game_status,
  output logic               game_over,
  output logic               over_pulse,
  output logic               jumping,
  output logic [11:0]        jump_time,
  output logic [11:0]        height,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         speed_lvl
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int STEP_W = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(SPEED_STEP - 1);
  localparam logic [2:0]         SPEED_MAX = 3'(MAX_SPEED);
  localparam logic [11:0]        JUMP_LAST = 12'(JUMP_FRAMES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t            state;
  logic              btn_start_q;
  logic              btn_jump_q;
  logic              hit;
  logic              jump_req;
  logic [STEP_W-1:0] step_cnt;

  logic        start_edge;
  logic        jump_edge;
  logic [23:0] jt_ext;
  logic [23:0] arc_prod;
  logic [11:0] height_next;

  assign start_edge = btn_start & ~btn_start_q;
  assign jump_edge  = btn_jump & ~btn_jump_q;

  // Parabolic arc: t*(N - t)/6, kept in 24 bits so the products never overflow.
  assign jt_ext      = {12'd0, jump_time};
  assign arc_prod    = jt_ext * 24'(JUMP_FRAMES) - jt_ext * jt_ext;
  assign height_next = 12'(arc_prod / 24'd6);

  // Button history for rising-edge detection, sampled every clock.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      btn_start_q <= 1'b0;
      btn_jump_q  <= 1'b0;
    end else begin
      btn_start_q <= btn_start;
      btn_jump_q  <= btn_jump;
    end
  end

  // Height trails jump_time by one clock; a fresh game starts on the ground.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      height <= 12'd0;
    end else if (state == IDLE && start_edge) begin
      height <= 12'd0;
    end else begin
      height <= height_next;
    end
  end

  // Game state machine with score, speed, jump schedule and registered status outputs.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      game_status <= 1'b0;
      game_over   <= 1'b0;
      over_pulse  <= 1'b0;
      jumping     <= 1'b0;
      jump_time   <= 12'd0;
      score       <= '0;
      speed_lvl   <= 3'd0;
      step_cnt    <= '0;
      hit         <= 1'b0;
      jump_req    <= 1'b0;
    end else begin
      over_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state       <= RUN;
            game_status <= 1'b1;
            score       <= '0;
            speed_lvl   <= 3'd0;
            step_cnt    <= '0;
            jump_time   <= 12'd0;
            jumping     <= 1'b0;
            hit         <= 1'b0;
            jump_req    <= 1'b0;
          end
        end
        RUN: begin
          if (start_edge) begin
            // The button wins over a coincident tick, which is then dropped.
            state       <= PAUSE;
            game_status <= 1'b0;
            hit         <= 1'b0;
          end else if (frame_tick) begin
            hit      <= 1'b0;
            jump_req <= 1'b0;
            if (hit || collision) begin
              state       <= OVER;
              game_status <= 1'b0;
              game_over   <= 1'b1;
              over_pulse  <= 1'b1;
            end else begin
              if (score != SCORE_MAX) begin
                score <= score + SCORE_W'(1);
              end
              if (step_cnt == STEP_LAST) begin
                step_cnt <= '0;
                if (speed_lvl != SPEED_MAX) begin
                  speed_lvl <= speed_lvl + 3'd1;
                end
              end else begin
                step_cnt <= step_cnt + STEP_W'(1);
              end
              if (jumping) begin
                if (jump_time >= JUMP_LAST) begin
                  jump_time <= 12'd0;
                  jumping   <= 1'b0;
                end else begin
                  jump_time <= jump_time + 12'd1;
                end
              end else if (jump_req) begin
                // Airborne from this frame; the first advance comes on the next tick.
                jumping <= 1'b1;
              end
            end
          end else begin
            if (collision) begin
              hit <= 1'b1;
            end
            if (jump_edge && !jumping) begin
              jump_req <= 1'b1;
            end
          end
        end
        PAUSE: begin
          if (start_edge) begin
            state       <= RUN;
            game_status <= 1'b1;
          end
        end
        OVER: begin
          if (start_edge) begin
            state     <= IDLE;
            game_over <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          game_status <= 1'b0;
          game_over   <= 1'b0;
        end
      endcase
    end
  end

endmodule
